// File: rtl/wb_stage_pkg.sv
// Shared widths and load funct3 encodings for the writeback stage.
package wb_stage_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Aligns a raw memory doubleword by the byte offset and applies the
// width/sign extension selected by the load funct3. Purely combinational.
module load_extend
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;

  // Bytes past the top of the doubleword fill with zero; misaligned
  // accesses that cross it are not trapped here.
  assign shifted = mem_data >> {offset, 3'b000};

  // Width and sign selection; 3'b111 falls through to the full doubleword.
  always_comb begin
    value = shifted;
    unique case (funct3)
      F3_LB:   value = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   value = shifted;
      F3_LBU:  value = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  value = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux. Drives the register file
// write port, mirrors it as a bypass source, and counts retirements.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_mem_data,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic [CNT_W-1:0]      retired_count
);

  logic                  valid_q,      valid_d;
  logic                  reg_write_q,  reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [REG_ADDR_W-1:0] rd_q,         rd_d;
  logic [2:0]            funct3_q,     funct3_d;
  logic [XLEN-1:0]       alu_q,        alu_d;
  logic [XLEN-1:0]       mem_q,        mem_d;
  logic [CNT_W-1:0]      retired_q,    retired_d;
  logic [XLEN-1:0]       load_value;

  // Next-state: reset clears everything, flush only kills the incoming
  // entry, otherwise capture. The counter retires the entry currently held.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    alu_d        = alu_q;
    mem_d        = mem_q;
    retired_d    = retired_q;
    if (rst) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      rd_d         = '0;
      funct3_d     = '0;
      alu_d        = '0;
      mem_d        = '0;
      retired_d    = '0;
    end else begin
      if (valid_q) retired_d = retired_q + CNT_W'(1);
      if (flush) begin
        valid_d = 1'b0;
      end else begin
        valid_d      = in_valid;
        reg_write_d  = in_reg_write;
        mem_to_reg_d = in_mem_to_reg;
        rd_d         = in_rd;
        funct3_d     = in_funct3;
        alu_d        = in_alu_result;
        mem_d        = in_mem_data;
      end
    end
  end

  // Pipeline register and retirement counter.
  always_ff @(posedge clk) begin
    valid_q      <= valid_d;
    reg_write_q  <= reg_write_d;
    mem_to_reg_q <= mem_to_reg_d;
    rd_q         <= rd_d;
    funct3_q     <= funct3_d;
    alu_q        <= alu_d;
    mem_q        <= mem_d;
    retired_q    <= retired_d;
  end

  load_extend u_load_extend (
    .mem_data (mem_q),
    .offset   (alu_q[2:0]),
    .funct3   (funct3_q),
    .value    (load_value)
  );

  // An entry still held while rst is asserted must not reach the file.
  assign rf_write_enable = valid_q & reg_write_q & (rd_q != '0) & ~rst;
  assign rf_rd           = rd_q;
  assign rf_wd           = !valid_q     ? '0 :
                           mem_to_reg_q ? load_value : alu_q;

  // The register file read is not write-through, so the bypass sees the
  // write port directly.
  assign fwd_valid     = rf_write_enable;
  assign fwd_rd        = rf_rd;
  assign fwd_data      = rf_wd;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_reg_write, in_mem_to_reg;
  logic [4:0]      in_rd;
  logic [2:0]      in_funct3;
  logic [63:0]     in_alu_result, in_mem_data;
  logic            rf_write_enable, fwd_valid;
  logic [4:0]      rf_rd, fwd_rd;
  logic [63:0]     rf_wd, fwd_data, retired_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit model_on = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_rd(in_rd), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .rf_write_enable(rf_write_enable),
    .rf_rd(rf_rd), .rf_wd(rf_wd), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .retired_count(retired_count)
  );

  // Model: byte-wise load, the one-deep entry held, and a count.
  function automatic logic [63:0] load_model(input logic [63:0] mem,
                                             input int off, input logic [2:0] f3);
    logic [7:0]  b [8];
    logic [63:0] r;
    int          nbytes;
    bit          neg;
    nbytes = 1 << f3[1:0];
    for (int j = 0; j < 8; j++)
      b[j] = (j + off < 8) ? mem[8*(j+off) +: 8] : 8'h00;
    neg = (f3[2] == 1'b0) && (nbytes < 8) && b[nbytes-1][7];
    for (int j = 0; j < 8; j++)
      r[8*j +: 8] = (j < nbytes) ? b[j] : (neg ? 8'hFF : 8'h00);
    return r;
  endfunction

  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [63:0] m_alu, m_mem, m_cnt;
  logic [63:0] rf_model [32];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_f3 = 0;
      m_alu = 0; m_mem = 0; m_cnt = 0;
    end else begin
      if (m_valid) m_cnt = m_cnt + 1;
      if (flush) m_valid = 0;
      else begin
        m_valid = in_valid; m_rw = in_reg_write; m_m2r = in_mem_to_reg;
        m_rd = in_rd; m_f3 = in_funct3; m_alu = in_alu_result; m_mem = in_mem_data;
      end
    end
  end

  // Register file fed from the DUT write port.
  always @(posedge clk)
    if (rf_write_enable) rf_model[rf_rd] <= rf_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      logic        e_we;
      logic [63:0] e_wd;
      e_we = m_valid && m_rw && (m_rd != 0) && !rst;
      e_wd = !m_valid ? 64'd0 : (m_m2r ? load_model(m_mem, int'(m_alu[2:0]), m_f3) : m_alu);
      check("m_we",   64'(rf_write_enable), 64'(e_we));
      check("m_rd",   64'(rf_rd),           64'(m_rd));
      check("m_wd",   rf_wd,                e_wd);
      check("m_fv",   64'(fwd_valid),       64'(e_we));
      check("m_frd",  64'(fwd_rd),          64'(m_rd));
      check("m_fd",   fwd_data,             e_wd);
      check("m_cnt",  retired_count,        m_cnt);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] mem);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = rd;
    in_funct3 = f3; in_alu_result = alu; in_mem_data = mem;
  endtask

  task automatic idle();
    drive(0, 0, 0, 5'd0, 3'd0, 64'd0, 64'd0);
  endtask

  localparam logic [63:0] MEMPAT = 64'h0123_4567_89AB_CDEF;

  initial begin
    logic [63:0] c0;
    rst = 1; flush = 0; idle();
    step(); step();
    model_on = 1;
    rst = 0;
    sample();
    check("rst_we",  64'(rf_write_enable), 64'd0);
    check("rst_wd",  rf_wd, 64'd0);
    check("rst_rd",  64'(rf_rd), 64'd0);
    check("rst_cnt", retired_count, 64'd0);

    // ALU write to x1, then read back from the register file.
    drive(1, 1, 0, 5'd1, 3'd0, 64'hA5A5A5A5A5A5A5A5, 64'd0);
    step(); idle();
    check("alu_we", 64'(rf_write_enable), 64'd1);
    check("alu_rd", 64'(rf_rd), 64'd1);
    check("alu_wd", rf_wd, 64'hA5A5A5A5A5A5A5A5);
    step();
    check("rf_x1", rf_model[1], 64'hA5A5A5A5A5A5A5A5);

    // Load extension cases.
    drive(1, 1, 1, 5'd5, F3_LB, 64'h1001, MEMPAT);  step();
    check("lb",  rf_wd, 64'hFFFF_FFFF_FFFF_FFCD);
    drive(1, 1, 1, 5'd5, F3_LBU, 64'h1001, MEMPAT); step();
    check("lbu", rf_wd, 64'h0000_0000_0000_00CD);
    drive(1, 1, 1, 5'd5, F3_LW, 64'h2004, MEMPAT);  step();
    check("lw4", rf_wd, 64'h0000_0000_0123_4567);
    drive(1, 1, 1, 5'd5, F3_LW, 64'h2000, MEMPAT);  step();
    check("lw0", rf_wd, 64'hFFFF_FFFF_89AB_CDEF);
    drive(1, 1, 1, 5'd5, F3_LH, 64'h0007, MEMPAT);  step();
    check("lh7", rf_wd, 64'h0000_0000_0000_0001);
    idle(); step();

    // x0 suppression still retires.
    c0 = retired_count;
    drive(1, 1, 0, 5'd0, 3'd0, 64'h5A5A5A5A5A5A5A5A, 64'd0);
    step(); idle();
    check("x0_we", 64'(rf_write_enable), 64'd0);
    step();
    check("x0_cnt", retired_count, c0 + 64'd1);

    // Flush: prior entry writes, flushed one neither writes nor retires.
    c0 = retired_count;
    drive(1, 1, 0, 5'd3, 3'd0, 64'h33, 64'd0);
    step();
    check("fl_prev_we", 64'(rf_write_enable), 64'd1);
    drive(1, 1, 0, 5'd4, 3'd0, 64'h44, 64'd0); flush = 1;
    step(); flush = 0; idle();
    check("fl_we",   64'(rf_write_enable), 64'd0);
    check("fl_cnt1", retired_count, c0 + 64'd1);
    step();
    check("fl_cnt2", retired_count, c0 + 64'd1);
    check("rf_x3",   rf_model[3], 64'h33);

    // Reset with a live entry in x2.
    drive(1, 1, 0, 5'd2, 3'd0, 64'h22, 64'd0);
    step(); idle(); rst = 1;
    sample();
    check("mr_we", 64'(rf_write_enable), 64'd0);
    step(); rst = 0;
    check("mr_cnt", retired_count, 64'd0);
    check("mr_wd",  rf_wd, 64'd0);
    check("mr_rd",  64'(rf_rd), 64'd0);

    // Ten back-to-back retirements.
    for (int i = 0; i < 10; i++) begin
      drive(1, i[0], 0, 5'(i + 6), 3'd0, 64'(i), 64'd0);
      step();
    end
    idle(); step();
    check("cnt10", retired_count, 64'd10);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom});
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0; flush = 0; idle();
    step(); step();
    sample();
    model_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 64-bit RV64I core.
- Latches one memory-stage result per cycle.
- Selects the ALU result or the aligned, sign/zero-extended load data.
- Drives the RegisterFile write port (write_enable, rd, wd) and exposes the same data as a forwarding source for the decode/execute bypass. Counts retired instructions.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the instruction being captured this edge
- in_valid  in  1  MEM stage presents a valid instruction
- in_reg_write  in  1  instruction writes rd
- in_mem_to_reg  in  1  1 = load result, 0 = ALU result
- in_rd  in  REG_ADDR_W  destination register
- in_funct3  in  3  load width/sign encoding
- in_alu_result  in  XLEN  ALU result; bits [2:0] are the load byte offset
- in_mem_data  in  XLEN  raw naturally-aligned 64-bit memory doubleword
- rf_write_enable  out  1  to RegisterFile.write_enable
- rf_rd  out  REG_ADDR_W  to RegisterFile.rd
- rf_wd  out  XLEN  to RegisterFile.wd
- fwd_valid  out  1  forwarding entry valid (equals rf_write_enable)
- fwd_rd  out  REG_ADDR_W  forwarding register index
- fwd_data  out  XLEN  forwarding data (equals rf_wd)
- retired_count  out  64  number of valid instructions retired

Behaviour:
- Register update, priority rst > flush > capture:
  - rst: clear valid, reg_write, mem_to_reg, rd, funct3, alu_result, mem_data and retired_count to 0.
  - flush: clear valid only.
  - otherwise capture all in_* fields, with valid <= in_valid.
- Latency: an input sampled at edge N drives the rf_* outputs during cycle N+1. The RegisterFile commits it at edge N+1.
- Each entry lives exactly one cycle, so no double write occurs.
- rf_write_enable = valid & reg_write & (rd != 0) & !rst.
  - Writes to x0 are suppressed.
  - An entry present while rst is high does not write.
- rf_rd = latched rd.
- rf_wd = mem_to_reg ? load_value : alu_result. rf_wd is 0 while valid is 0.
- Load alignment: shifted = mem_data >> (8 * alu_result[2:0]). Bits shifted in are 0.
- Load extension by funct3:
  - 000 LB: sign-extend shifted[7:0]
  - 001 LH: sign-extend shifted[15:0]
  - 010 LW: sign-extend shifted[31:0]
  - 011 LD: shifted
  - 100 LBU: zero-extend [7:0]
  - 101 LHU: zero-extend [15:0]
  - 110 LWU: zero-extend [31:0]
  - 111: shifted, treated as LD
- Misaligned loads that cross the doubleword take zero-filled upper bytes. No trap is raised here.
- Forwarding outputs are combinational copies of the rf_* outputs. They are for the bypass, because the RegisterFile read is not write-through.
- retired_count increments by 1 on every edge where valid & !rst, independent of reg_write (stores and branches count). It wraps from 2^64-1 to 0.
- flush and in_valid high together: nothing is captured.
- The current entry still writes, because flush only affects the next entry.

Decomposition:
- Shared package holds XLEN, REG_ADDR_W and the load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU).
- One combinational sub-module, load_extend (inputs: mem_data, offset[2:0], funct3; output: XLEN value), instantiated once inside wb_stage.

Test Plan:
- ALU write: in_valid=1, reg_write=1, mem_to_reg=0, rd=1, alu=64'hA5A5A5A5A5A5A5A5 -> next cycle rf_write_enable=1, rf_rd=1, rf_wd=A5A5A5A5A5A5A5A5; RegisterFile rs1=1 then reads A5A5A5A5A5A5A5A5.
- Load extension:
  - mem_data=64'h0123_4567_89AB_CDEF, offset=1, LB -> rf_wd=FFFF_FFFF_FFFF_FFCD.
  - Same offset with LBU -> 0000_0000_0000_00CD.
  - offset=4, LW -> 0000_0000_0123_4567.
  - offset=0, LW -> FFFF_FFFF_89AB_CDEF.
- x0 suppression: valid, reg_write=1, rd=0, alu=64'h5A5A... -> rf_write_enable=0; retired_count still increments by 1.
- Flush: in_valid=1 with flush=1 -> next cycle rf_write_enable=0 and retired_count unchanged. An entry captured the cycle before still writes normally.
- Reset mid-operation:
  - rst asserted while a valid entry (rd=2) is latched -> rf_write_enable=0 that cycle.
  - After the edge, retired_count=0 and all outputs are 0.
- Counter: 10 consecutive valid entries -> retired_count=10 one cycle after the last.
